// File: rtl/stack_mc_controller.sv
// Multicycle Moore control unit for the 8-bit stack-machine datapath.
// Sequences fetch/decode/stack/ALU/memory/jump micro-steps per clock.
module stack_mc_controller #(
  parameter int OPC_W   = 3,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   OPC,
  output logic               IorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               IRWrite,
  output logic               SrcA,
  output logic               SrcB,
  output logic               LdA,
  output logic               LdB,
  output logic [ALUOP_W-1:0] AluOP,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               tos,
  output logic               Push,
  output logic               Pop,
  output logic               PCWriteCond,
  output logic               MtoS,
  output logic               instDone,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_POPA  = 4'd2,
    S_POPB  = 4'd3,
    S_EXE   = 4'd4,
    S_WB    = 4'd5,
    S_MEMRD = 4'd6,
    S_MPUSH = 4'd7,
    S_POPST = 4'd8,
    S_MEMWR = 4'd9,
    S_JMP   = 4'd10,
    S_JZ    = 4'd11
  } state_e;

  typedef struct packed {
    logic               iord;
    logic               memrd;
    logic               memwr;
    logic               irwr;
    logic               srca;
    logic               srcb;
    logic               lda;
    logic               ldb;
    logic [ALUOP_W-1:0] aluop;
    logic               pcwr;
    logic               pcsrc;
    logic               tos;
    logic               push;
    logic               pop;
    logic               pcwrc;
    logic               mtos;
    logic               done;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctl_q, ctl_d;
  logic   run_q;

  // run_q holds IF for one edge after reset so fetch starts cleanly
  always_comb begin
    state_d = S_IF;
    if (run_q) begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          unique case (1'b1)
            !OPC[2]:               state_d = S_POPA;
            OPC[2:0] == 3'b100:    state_d = S_MEMRD;
            OPC[2:0] == 3'b101:    state_d = S_POPST;
            OPC[2:0] == 3'b110:    state_d = S_JMP;
            OPC[2:0] == 3'b111:    state_d = S_JZ;
            default:               state_d = S_IF;
          endcase
        end
        S_POPA: begin
          if (OPC[1:0] == 2'b11) state_d = S_EXE;
          else                   state_d = S_POPB;
        end
        S_POPB:  state_d = S_EXE;
        S_EXE:   state_d = S_WB;
        S_MEMRD: state_d = S_MPUSH;
        S_POPST: state_d = S_MEMWR;
        default: state_d = S_IF;
      endcase
    end
  end

  // outputs are decoded from the next state and registered
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_IF: begin
        ctl_d.memrd = 1'b1;
        ctl_d.irwr  = 1'b1;
        ctl_d.srca  = 1'b1;
        ctl_d.srcb  = 1'b1;
        ctl_d.pcwr  = 1'b1;
      end
      S_ID: ctl_d.tos = 1'b1;
      S_POPA, S_POPST: begin
        ctl_d.tos = 1'b1;
        ctl_d.lda = 1'b1;
        ctl_d.pop = 1'b1;
      end
      S_POPB: begin
        ctl_d.tos = 1'b1;
        ctl_d.ldb = 1'b1;
        ctl_d.pop = 1'b1;
      end
      S_EXE: ctl_d.aluop = OPC[ALUOP_W-1:0];
      S_WB: begin
        ctl_d.push = 1'b1;
        ctl_d.done = 1'b1;
      end
      S_MEMRD: begin
        ctl_d.iord  = 1'b1;
        ctl_d.memrd = 1'b1;
      end
      S_MPUSH: begin
        ctl_d.mtos = 1'b1;
        ctl_d.push = 1'b1;
        ctl_d.done = 1'b1;
      end
      S_MEMWR: begin
        ctl_d.iord  = 1'b1;
        ctl_d.memwr = 1'b1;
        ctl_d.done  = 1'b1;
      end
      S_JMP: begin
        ctl_d.pcsrc = 1'b1;
        ctl_d.pcwr  = 1'b1;
        ctl_d.done  = 1'b1;
      end
      S_JZ: begin
        ctl_d.pcsrc = 1'b1;
        ctl_d.pcwrc = 1'b1;
        ctl_d.done  = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      ctl_q   <= ctl_d;
    end
  end

  assign IorD        = ctl_q.iord;
  assign memRead     = ctl_q.memrd;
  assign memWrite    = ctl_q.memwr;
  assign IRWrite     = ctl_q.irwr;
  assign SrcA        = ctl_q.srca;
  assign SrcB        = ctl_q.srcb;
  assign LdA         = ctl_q.lda;
  assign LdB         = ctl_q.ldb;
  assign AluOP       = ctl_q.aluop;
  assign PCWrite     = ctl_q.pcwr;
  assign PCSrc       = ctl_q.pcsrc;
  assign tos         = ctl_q.tos;
  assign Push        = ctl_q.push;
  assign Pop         = ctl_q.pop;
  assign PCWriteCond = ctl_q.pcwrc;
  assign MtoS        = ctl_q.mtos;
  assign instDone    = ctl_q.done;
  assign state       = state_q;

endmodule

// File: doc/stack_mc_controller.md
Name: stack_mc_controller

Overview:
- Multicycle control unit for the 8-bit stack-machine datapath (5-bit PC/address, 8-bit IR/MDR/A/B/Z/ALUOut, hardware stack).
- Moore FSM: takes the 3-bit opcode from the datapath and drives every datapath control line, one micro-step per clock.
- Sequences fetch, decode, stack pops/pushes, ALU execute, memory read/write and jumps for the 8-instruction ISA.

Parameters:
- OPC_W, 3, opcode width (IR[7:5])
- ALUOP_W, 2, ALU function select width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- OPC  input  3  opcode from IR[7:5]
- IorD  output  1  memory address select: 0=PC, 1=IR[4:0]
- memRead  output  1  memory read enable
- memWrite  output  1  memory write enable (write data = A)
- IRWrite  output  1  IR load
- SrcA  output  1  ALU input 1: 0=A, 1=zero-extended PC
- SrcB  output  1  ALU input 2: 0=B, 1=constant 1
- LdA  output  1  A load from stack d_out
- LdB  output  1  B load from stack d_out
- AluOP  output  2  00=ADD, 01=SUB(in1-in2), 10=AND, 11=NOT(in1)
- PCWrite  output  1  unconditional PC load
- PCSrc  output  1  PC source: 0=ALU, 1=IR[4:0]
- tos  output  1  stack drives top-of-stack on d_out
- Push  output  1  push stack d_in at clock edge
- Pop  output  1  pop stack at clock edge
- PCWriteCond  output  1  PC load qualified by datapath zero flag (Z==0)
- MtoS  output  1  stack d_in: 0=ALUOut, 1=MDR
- instDone  output  1  one-cycle pulse in the last state of every instruction
- state  output  4  current state code (debug)

Behaviour:
- ISA: OPC 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- Moore outputs: every output not listed for a state is 0.
- While rst=0: state=IF (code 0) and all outputs forced to 0, including memRead/IRWrite/PCWrite.
- Reset mid-instruction aborts the instruction; fetch restarts on the first rising edge after rst releases.
- States, their asserted outputs, and next state:
  - IF(0): memRead, IRWrite, SrcA, SrcB, AluOP=00, PCWrite (PC<=PC+1) -> ID.
  - ID(1): tos (Z captures TOS) -> by OPC: 000-011 POPA; 100 MEMRD; 101 POPST; 110 JMP; 111 JZ.
  - POPA(2): tos, LdA, Pop -> NOT: EXE; else POPB.
  - POPB(3): tos, LdB, Pop -> EXE.
  - EXE(4): SrcA=0, SrcB=0, AluOP=OPC[1:0] (ALUOut latched) -> WB.
  - WB(5): MtoS=0, Push, instDone -> IF.
  - MEMRD(6): IorD, memRead (MDR latched) -> MPUSH.
  - MPUSH(7): MtoS=1, Push, instDone -> IF.
  - POPST(8): tos, LdA, Pop -> MEMWR.
  - MEMWR(9): IorD, memWrite, instDone -> IF.
  - JMP(10): PCSrc=1, PCWrite, instDone -> IF.
  - JZ(11): PCSrc=1, PCWriteCond, instDone -> IF. JZ does not pop.
- Latency (cycles, IF to last state): ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 3.
- Push and Pop are never asserted in the same state.
- memRead and memWrite are never asserted in the same state.
- IorD=1 only in MEMRD/MEMWR.
- Codes 12-15 are unreachable; if entered, go to IF with all outputs 0.
- OPC is sampled only in ID (and in POPA for the NOT branch). IR changes only in IF, so OPC is stable for the rest of the instruction.

Test Plan:
- Reset: hold rst=0 across 3 edges with OPC=000 -> all outputs 0, state=0. Release -> first cycle IF: memRead=IRWrite=PCWrite=SrcA=SrcB=1, AluOP=00.
- ADD: OPC=000 -> state sequence 0,1,2,3,4,5,0. LdA+Pop in state 2, LdB+Pop in state 3. AluOP=00 in state 4. Push=1 with MtoS=0 and instDone=1 in state 5. Total 6 cycles.
- NOT then SUB: OPC=011 -> sequence 0,1,2,4,5 (no state 3), AluOP=11 in EXE. Next OPC=001 -> AluOP=01 in EXE.
- PUSH/POP: OPC=100 -> 0,1,6,7 with IorD=memRead=1 in 6 and Push=MtoS=1 in 7. OPC=101 -> 0,1,8,9 with LdA=Pop=tos=1 in 8 and IorD=memWrite=1 in 9.
- Jumps: OPC=110 -> state 10 with PCSrc=PCWrite=1. OPC=111 -> state 11 with PCSrc=PCWriteCond=1, PCWrite=0, Pop=0. Each takes 3 cycles.
- Async reset mid-op: drop rst during EXE of SUB (between edges) -> outputs 0 immediately without a clock edge, state=0. After release the next instruction fetch starts cleanly with no stray Push.
